// File: rtl/rendering_mul_arbiter.sv
// -----------------------------------------------------------------------------
// rendering_mul_arbiter
//
// Shares one signed DIN0_WIDTH x DIN1_WIDTH multiplier between NUM_REQ
// requesters. Each requester has at most one multiply outstanding. A
// combinational round-robin arbiter grants at most one request per cycle, and
// each product lands in that requester's own registered response slot.
//
// Build option: define RENDERING_MUL_ARB_PIPE_EN to add an operand register
// stage ahead of the multiplier (latency 2 instead of 1).
//
// Ports
//   ap_clk     in   clock, rising edge
//   ap_rst_n   in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]            requester i presents operands
//   req_ready  out  [NUM_REQ]            one-hot grant (or zero) this cycle
//   req_a      in   [NUM_REQ*DIN0_WIDTH] operand A, slice i per requester
//   req_b      in   [NUM_REQ*DIN1_WIDTH] operand B, slice i per requester
//   rsp_valid  out  [NUM_REQ]            slot i holds a product
//   rsp_ready  in   [NUM_REQ]            requester i consumes slot i
//   rsp_data   out  [NUM_REQ*DOUT_WIDTH] registered product per slot
//
// DOUT_WIDTH must equal DIN0_WIDTH + DIN1_WIDTH.
// -----------------------------------------------------------------------------
module rendering_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 9,
  parameter int DIN1_WIDTH = 9,
  parameter int DOUT_WIDTH = 18
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_a,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_b,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [NUM_REQ*DOUT_WIDTH-1:0]    rsp_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DOUT_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]            in_flight;
  logic [NUM_REQ-1:0]            eligible;
  logic [IDX_W-1:0]              cand;
  logic                          grant_vld;
  logic [IDX_W-1:0]              grant_idx;
  logic signed [DIN0_WIDTH-1:0]  grant_a;
  logic signed [DIN1_WIDTH-1:0]  grant_b;

  // Operands actually feeding the multiplier and the slot they target.
  logic signed [DIN0_WIDTH-1:0]  op_a;
  logic signed [DIN1_WIDTH-1:0]  op_b;
  logic                          wr_vld;
  logic [IDX_W-1:0]              wr_idx;
  logic signed [DOUT_WIDTH-1:0]  mul_a, mul_b, product;

  // (base + off) mod NUM_REQ, with off < NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Round-robin search starting at rr_ptr_q. Eligibility looks only at
  // registered state, so a slot draining this cycle still blocks its owner
  // until the next cycle and req_ready never depends on rsp_ready.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    eligible  = req_valid & ~rsp_valid_q & ~in_flight;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_index(rr_ptr_q, k);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (!ap_rst_n) grant_vld = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant_idx] = 1'b1;
  end

  // Granted operand mux.
  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_a = req_a[i*DIN0_WIDTH +: DIN0_WIDTH];
        grant_b = req_b[i*DIN1_WIDTH +: DIN1_WIDTH];
      end
    end
  end

`ifdef RENDERING_MUL_ARB_PIPE_EN
  logic                         stg_valid_q, stg_valid_d;
  logic [IDX_W-1:0]             stg_idx_q, stg_idx_d;
  logic signed [DIN0_WIDTH-1:0] stg_a_q, stg_a_d;
  logic signed [DIN1_WIDTH-1:0] stg_b_q, stg_b_d;

  always_comb begin
    stg_valid_d = grant_vld;
    stg_idx_d   = grant_idx;
    stg_a_d     = grant_a;
    stg_b_d     = grant_b;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stg_valid_q <= 1'b0;
      stg_idx_q   <= '0;
      stg_a_q     <= '0;
      stg_b_q     <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_idx_q   <= stg_idx_d;
      stg_a_q     <= stg_a_d;
      stg_b_q     <= stg_b_d;
    end
  end

  // The requester sitting in the stage has no slot yet but must not be
  // granted again until its product is written.
  always_comb begin
    in_flight = '0;
    if (stg_valid_q) in_flight[stg_idx_q] = 1'b1;
  end

  assign op_a   = stg_a_q;
  assign op_b   = stg_b_q;
  assign wr_vld = stg_valid_q;
  assign wr_idx = stg_idx_q;
`else
  assign in_flight = '0;
  assign op_a      = grant_a;
  assign op_b      = grant_b;
  assign wr_vld    = grant_vld;
  assign wr_idx    = grant_idx;
`endif

  // Sign-extend to full output width first; the exact product always fits.
  assign mul_a   = DOUT_WIDTH'(op_a);
  assign mul_b   = DOUT_WIDTH'(op_b);
  assign product = mul_a * mul_b;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld)
      rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  end

  // A slot being written is always empty (its owner was ineligible otherwise),
  // so drain and write never collide on the same slot.
  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_vld && wr_idx == IDX_W'(i)) begin
        rsp_valid_d[i]                          = 1'b1;
        rsp_data_d[i*DOUT_WIDTH +: DOUT_WIDTH]  = product;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      // NOTE: the response storage is reset on purpose: consumers may look at
      // rsp_data straight out of reset and must see zero.
      rsp_data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours.
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rendering_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rendering_mul_arbiter
//
// Behavioural reference: each requester is either idle or "busy" from grant
// until the cycle its product is consumed. The product becomes visible LAT
// cycles after the grant. Grants are found by scanning from a round-robin
// pointer. Expected products are queued at grant time; a separate monitor
// pops and compares them when the DUT presents a response.
// -----------------------------------------------------------------------------
module tb_rendering_mul_arbiter;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int BW = 9;
  localparam int DW = 18;
`ifdef RENDERING_MUL_ARB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            ap_clk = 1'b0;
  logic            ap_rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a = '0;
  logic [N*BW-1:0] req_b = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [N*DW-1:0] rsp_data;

  always #5 ap_clk = ~ap_clk;

  rendering_mul_arbiter #(
    .NUM_REQ(N), .DIN0_WIDTH(AW), .DIN1_WIDTH(BW), .DOUT_WIDTH(DW)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  typedef struct {
    int idx;
    int val;
  } exp_t;

  exp_t       exp_q[$];
  bit         busy[N];
  int         due[N];
  int         ptr = 0;
  int         cyc = 0;
  logic [N-1:0] acc = '0;   // requests accepted at the upcoming edge

  function automatic int opa(input int i);
    return int'($signed(req_a[i*AW +: AW]));
  endfunction

  function automatic int opb(input int i);
    return int'($signed(req_b[i*BW +: BW]));
  endfunction

  // Reference model: predicts req_ready and rsp_valid every cycle.
  always @(negedge ap_clk) begin : model
    logic [N-1:0] exp_ready;
    logic [N-1:0] full;
    int g;
    if (!ap_rst_n) begin
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      for (int i = 0; i < N; i++) busy[i] = 1'b0;
      ptr = 0;
      exp_q.delete();
      acc = '0;
    end else begin
      full = '0;
      for (int i = 0; i < N; i++) full[i] = busy[i] && (cyc >= due[i]);
      g = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (g < 0 && req_valid[c] && !busy[c]) g = c;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", int'(req_ready), int'(exp_ready));
      check("rsp_valid", int'(rsp_valid), int'(full));
      for (int i = 0; i < N; i++)
        if (full[i] && rsp_ready[i]) busy[i] = 1'b0;
      if (g >= 0) begin
        busy[g] = 1'b1;
        due[g]  = cyc + LAT;
        exp_q.push_back('{idx: g, val: opa(g) * opb(g)});
        ptr = (g + 1) % N;
      end
      acc = req_valid & req_ready;
    end
    cyc++;
  end

  // Monitor: compares slot contents against the queued products.
  int last_val[N];
  always @(negedge ap_clk) begin : monitor
    for (int i = 0; i < N; i++) begin
      int got;
      got = int'($signed(rsp_data[i*DW +: DW]));
      if (!ap_rst_n) begin
        check("rst_rsp_data", got, 0);
        last_val[i] = 0;
      end else if (rsp_valid[i]) begin
        int cnt;
        int pos;
        cnt = 0;
        pos = -1;
        for (int k = 0; k < exp_q.size(); k++)
          if (exp_q[k].idx == i) begin
            cnt++;
            if (pos < 0) pos = k;
          end
        check("rsp_pending", cnt, 1);
        if (pos >= 0) begin
          check("rsp_data", got, exp_q[pos].val);
          if (rsp_ready[i]) begin
            last_val[i] = exp_q[pos].val;
            exp_q.delete(pos);
          end
        end
      end else begin
        check("rsp_hold", got, last_val[i]);
      end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*AW +: AW] = AW'(a);
    req_b[i*BW +: BW] = BW'(b);
  endtask

  task automatic offer(input int i, input int a, input int b);
    req_valid[i] = 1'b1;
    set_ops(i, a, b);
  endtask

  task automatic wait_accept(input int i);
    for (int n = 0; n < 50; n++) begin
      step();
      if (acc[i]) break;
    end
    check("accept_timeout", int'(acc[i]), 1);
  endtask

  // All requesters in mask stay continuously valid; fresh operands on accept.
  task automatic rr_phase(input logic [N-1:0] mask, input int cycles);
    rsp_ready = '1;
    repeat (cycles) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          if (acc[i] || !req_valid[i]) offer(i, int'($urandom), int'($urandom));
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int corner_a[3];
    int corner_b[3];
    corner_a = '{-256, 255, 0};
    corner_b = '{-256, -256, -1};

    // Reset with every requester asking.
    req_valid = '1;
    for (int i = 0; i < N; i++) set_ops(i, int'($urandom), int'($urandom));
    #1 ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    wait_accept(0);
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) step();

    // Signed corners on requester 0.
    for (int c = 0; c < 3; c++) begin
      offer(0, corner_a[c], corner_b[c]);
      wait_accept(0);
      req_valid[0] = 1'b0;
      repeat (4) step();
    end

    // Round robin: everyone, then requester 2 idle.
    rr_phase(4'hF, 24);
    rr_phase(4'hB, 24);
    req_valid = '0;
    repeat (5) step();

    // Backpressure on slot 1.
    rsp_ready = 4'hD;
    offer(1, 100, -3);
    wait_accept(1);
    offer(1, 5, 5);
    repeat (8) step();
    rsp_ready[1] = 1'b1;
    step();
    rsp_ready[1] = 1'b0;
    repeat (4) step();
    rsp_ready = '1;
    wait_accept(1);
    req_valid = '0;
    repeat (5) step();

    // Reset while requester 3 is being granted.
    offer(3, 7, 9);
    for (int n = 0; n < 20; n++) begin
      @(negedge ap_clk);
      if (req_ready[3]) break;
    end
    check("grant3_seen", int'(req_ready[3]), 1);
    #2;
    ap_rst_n  = 1'b0;
    req_valid = '0;
    @(posedge ap_clk);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (5) step();
    rr_phase(4'hF, 12);
    req_valid = '0;
    repeat (5) step();

    // Random traffic with random backpressure.
    repeat (1500) begin
      step();
      rsp_ready = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          set_ops(i, int'($urandom), int'($urandom));
        end
      end
    end

    // Drain everything.
    req_valid = '0;
    rsp_ready = '1;
    repeat (8) step();
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
